// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// Accepts one request at a time, answers after a fixed LATENCY, and holds
// the response until the requester consumes it. Storage is a register array
// cleared by reset.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned LATENCY     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_adr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [1:0]    state_q;
   logic [3:0]    cnt_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept;
   logic          adr_err;
   logic [AW-1:0] idx;

   // Decode the request address into a word index and an error flag.
   always_comb begin
      idx     = req_adr[AW+1:2];
      adr_err = (req_adr[1:0] != 2'b00) || (req_adr[31:AW+2] != '0);
      accept  = req_valid && (state_q == S_IDLE);
   end

   // Handshake and response outputs; data is forced to zero outside RESP.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_RESP);
      resp_err   = (state_q == S_RESP) && err_q;
      resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
   end

   // Request/response sequencing with the latency down-counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (LATENCY > 1) begin
                     state_q <= S_WAIT;
                     cnt_q   <= LAT_M1;
                  end else begin
                     state_q <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               // The acceptance edge counts as the first of LATENCY edges,
               // so leaving when the counter is 1 lands RESP on edge LATENCY.
               if (cnt_q == 4'd1) begin
                  state_q <= S_RESP;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Capture the response payload at the acceptance edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         err_q   <= adr_err;
         rdata_q <= (!req_write && !adr_err) ? mem[idx] : '0;
      end
   end

   // Word storage: commit error-free writes at acceptance; cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (accept && req_write && !adr_err) begin
         mem[idx] <= req_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against
// a word-array reference model (LATENCY=3 and LATENCY=1 instances).
module tb_dmem_responder;

   localparam int unsigned DEPTH  = 64;
   localparam int unsigned LAT    = 3;
   localparam int unsigned BUDGET = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_adr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid1 = 1'b0, req_write1 = 1'b0, resp_ready1 = 1'b1;
   logic [31:0] req_adr1 = '0, req_wdata1 = '0;
   logic        req_ready1, resp_valid1, resp_err1;
   logic [31:0] resp_rdata1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] mem_m  [DEPTH];
   logic [31:0] mem_m1 [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_adr(req_adr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
      .req_adr(req_adr1), .req_wdata(req_wdata1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1),
      .resp_rdata(resp_rdata1), .resp_err(resp_err1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference behaviour: byte address -> word, error if misaligned or beyond storage.
   function automatic void model_op(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                                    input logic use1, output logic [31:0] er, output logic ee);
      ee = (adr % 4 != 0) || (adr >= 4 * DEPTH);
      er = '0;
      if (!ee) begin
         if (wr) begin
            if (use1) mem_m1[adr / 4] = wd; else mem_m[adr / 4] = wd;
         end else begin
            er = use1 ? mem_m1[adr / 4] : mem_m[adr / 4];
         end
      end
   endfunction

   task automatic clear_models();
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i]  = '0;
         mem_m1[i] = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the LATENCY=3 instance, holding the response for 'hold' cycles.
   task automatic do_req(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                         input int unsigned hold);
      logic [31:0] er;
      logic        ee;
      int unsigned n;
      model_op(wr, adr, wd, 1'b0, er, ee);
      req_write = wr; req_adr = adr; req_wdata = wd; req_valid = 1'b1; resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < BUDGET) begin tick(); n++; end
      check("accept_in_budget", 32'(n < BUDGET), 32'd1);
      tick();
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < BUDGET) begin tick(); n++; end
      check("latency", n, LAT);
      check("rdata", resp_rdata, er);
      check("err", 32'(resp_err), 32'(ee));
      repeat (hold) begin
         tick();
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, er);
         check("hold_err", 32'(resp_err), 32'(ee));
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("done_valid", 32'(resp_valid), 32'd0);
      check("done_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] er, hold_d;
      logic        ee, hold_e;
      int unsigned n;
      clear_models();

      // Reset state, observed while reset is held.
      tick(); tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst1_req_ready", 32'(req_ready1), 32'd1);
      rst = 1'b1;

      // Basic read, write/readback, error cases.
      do_req(1'b0, 32'h10, '0, 0);
      do_req(1'b1, 32'h20, 32'hDEADBEEF, 0);
      do_req(1'b0, 32'h20, '0, 0);
      do_req(1'b0, 32'h22, '0, 0);
      do_req(1'b0, 32'h100, '0, 0);
      do_req(1'b1, 32'h100, 32'hCAFEF00D, 0);
      do_req(1'b0, 32'h0, '0, 0);

      // Response held for 5 cycles while a second request is presented and must be ignored.
      model_op(1'b0, 32'h20, '0, 1'b0, hold_d, hold_e);
      req_write = 1'b0; req_adr = 32'h20; req_valid = 1'b1; resp_ready = 1'b0;
      tick();
      req_write = 1'b1; req_adr = 32'h24; req_wdata = 32'hA5A5A5A5;
      n = 1;
      while (!resp_valid && n < BUDGET) begin tick(); n++; end
      check("hold_latency", n, LAT);
      repeat (5) begin
         tick();
         check("stall_valid", 32'(resp_valid), 32'd1);
         check("stall_rdata", resp_rdata, hold_d);
         check("stall_err", 32'(resp_err), 32'(hold_e));
         check("stall_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check("release_valid", 32'(resp_valid), 32'd0);
      check("release_ready", 32'(req_ready), 32'd1);
      tick();
      check("no_second_accept", 32'(req_ready), 32'd1);
      do_req(1'b0, 32'h24, '0, 0);

      // Asynchronous reset during WAIT abandons the request and clears storage.
      model_op(1'b1, 32'h4, 32'h12345678, 1'b0, er, ee);
      req_write = 1'b1; req_adr = 32'h4; req_wdata = 32'h12345678; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("wait_ready", 32'(req_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("async_valid", 32'(resp_valid), 32'd0);
      check("async_ready", 32'(req_ready), 32'd1);
      check("async_rdata", resp_rdata, 32'd0);
      clear_models();
      tick();
      rst = 1'b1;
      do_req(1'b0, 32'h4, '0, 0);
      do_req(1'b0, 32'h20, '0, 0);

      // Randomized traffic, mostly in-range aligned, some misaligned/out-of-range.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         case ($urandom_range(0, 9))
            0:       a = $urandom();
            1:       a = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
            2:       a = 32'h100 + {$urandom_range(0, 63), 2'b00};
            default: a = {$urandom_range(0, 15), 2'b00};
         endcase
         do_req(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 3));
      end

      // LATENCY=1 instance: back-to-back requests, resp_ready tied high.
      req_valid1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic        w;
         logic [31:0] a;
         w = (i % 2 == 0);
         a = (i == 8) ? 32'h3 : 32'(((i / 2) % 4) * 4 + 8);
         check("l1_ready", 32'(req_ready1), 32'd1);
         req_write1 = w; req_adr1 = a; req_wdata1 = $urandom();
         model_op(w, a, req_wdata1, 1'b1, er, ee);
         tick();
         check("l1_valid", 32'(resp_valid1), 32'd1);
         check("l1_rdata", resp_rdata1, er);
         check("l1_err", 32'(resp_err1), 32'(ee));
         tick();
         check("l1_gap", 32'(resp_valid1), 32'd0);
      end
      req_valid1 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
